instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage of the CPU pipeline.
- Holds the PC and issues in-order word reads to instruction memory through a valid/ready request channel.
- Buffers returned words in a small FIFO and presents Instruction/Address pairs to instruction decode with a valid/ready handshake.
- Consumes PCSrc/BranchAddress from execution to redirect the PC and flush wrong-path instructions.

Parameters:
- ADDR_W, 64: width of PC, Address, BranchAddress, imem_req_addr.
- INSTR_W, 32: instruction word width.
- BUF_DEPTH, 2: instruction FIFO entries; also the maximum outstanding requests; power of 2, >=2.
- RESET_PC, 64'h0: PC loaded on reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- imem_req_valid  output  1  read request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  ADDR_W  word address of the request (bits [1:0] = 0)
- imem_rsp_valid  input  1  read data valid; responses arrive in order, never stalled
- imem_rsp_data  input  INSTR_W  read data
- PCSrc  input  1  redirect request from execution
- BranchAddress  input  ADDR_W  redirect target
- Instruction  output  INSTR_W  head-of-FIFO instruction
- Address  output  ADDR_W  PC of Instruction
- instr_valid  output  1  Instruction/Address valid
- instr_ready  input  1  decode consumes head
- perf_fetch_cnt  output  32  delivered-instruction count (FETCH_PERF_EN only)
- perf_flush_cnt  output  32  redirect count (FETCH_PERF_EN only)

Behaviour:
- Reset (synchronous):
  - PC=RESET_PC; FIFO empty; outstanding=0; stale=0; state=S_BOOT.
  - imem_req_valid=0, instr_valid=0, Instruction=0, Address=0; perf counters=0.
  - Reset overrides every other input in the same cycle.
- FSM states:
  - S_BOOT: one cycle, no request; then S_FETCH.
  - S_FETCH: imem_req_valid=1 when outstanding + fifo_count < BUF_DEPTH, with imem_req_addr=PC. A request is issued when imem_req_valid && imem_req_ready; PC advances by 4 (mod 2^ADDR_W, wraps silently) and outstanding increments.
  - S_DRAIN: entered on redirect when outstanding requests remain. imem_req_valid=0. Each response decrements stale and is discarded. When stale reaches 0 (or there are no responses to drain), move to S_FETCH at the next edge.
- Response handling:
  - In S_FETCH, each imem_rsp_valid pushes {imem_rsp_data, tag PC} into the FIFO and decrements outstanding.
  - The tag PC comes from an internal in-order address queue of depth BUF_DEPTH.
  - Credit accounting guarantees the FIFO never overflows, so responses are never dropped for lack of space.
- Decode handshake:
  - instr_valid = FIFO not empty. Instruction/Address come from the head combinationally from FIFO registers.
  - Pop when instr_valid && instr_ready. Push and pop in the same cycle are both performed.
  - Instruction/Address are held stable while instr_valid && !instr_ready.
- Redirect (PCSrc=1, sampled at the edge):
  - Next PC = {BranchAddress[ADDR_W-1:2], 2'b00}; misaligned low bits are ignored.
  - FIFO is flushed; instr_valid=0 in the next cycle.
  - stale = outstanding, including a request handshaked in the redirect cycle.
  - A response arriving in the redirect cycle is discarded and not counted as stale.
  - Next state is S_DRAIN if stale>0, else S_FETCH.
  - A pop in the redirect cycle is still honoured by decode, but the FIFO ends empty.
  - PCSrc asserted while in S_DRAIN: the PC is re-targeted, stale is unchanged (no new requests were issued), and the block remains in S_DRAIN.
- Latency: first instr_valid at the earliest 3 cycles after reset deasserts (BOOT, request, response registered), given a 1-cycle memory. Redirect to new-path request is 1 cycle when no requests are outstanding.

Optional Feature:
- Macro: FETCH_PERF_EN.
- With the macro defined:
  - perf_fetch_cnt increments on each decode pop.
  - perf_flush_cnt increments on each cycle PCSrc=1.
  - Both counters are 32-bit, wrap at 2^32, and clear on reset.
- Without the macro: no counter registers; both ports are driven constant 0, so the port list is unchanged.

Test Plan:
- Reset, 1-cycle memory returning word = addr^32'hA5A5_0000, instr_ready=1 -> Address sequence 0,4,8,12 with matching Instruction; first instr_valid 3 cycles after reset drop.
- instr_ready=0 for 10 cycles -> at most 2 requests outstanding or buffered; Instruction/Address stable at 0; no request issued while credit is exhausted; resumes in order after release.
- 3-cycle memory latency, PCSrc=1 with BranchAddress=64'h100 while 2 requests are outstanding -> FSM enters S_DRAIN, both stale responses discarded, next request addr 64'h100, first delivered Address 64'h100.
- BranchAddress=64'h203 -> fetch from 64'h200.
- PCSrc and imem_rsp_valid in the same cycle -> that response never appears on Instruction.
- Reset asserted mid-drain with 2 outstanding -> instr_valid=0, PC=RESET_PC, and late responses after reset are ignored only if they precede the first post-reset request (memory is modelled as also reset).
- With FETCH_PERF_EN: 5 pops and 2 redirects -> perf_fetch_cnt=5, perf_flush_cnt=2. Without the macro: both read 0.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, in-order imem requests, instruction FIFO and redirect/flush.
// Optional FETCH_PERF_EN macro adds delivered-instruction and redirect counters.
module instruction_fetch #(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       INSTR_W   = 32,
    parameter int unsigned       BUF_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               PCSrc,
    input  logic [ADDR_W-1:0]  BranchAddress,
    output logic [INSTR_W-1:0] Instruction,
    output logic [ADDR_W-1:0]  Address,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_flush_cnt
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]    outst_q, outst_d;
    logic [CNT_W-1:0]    stale_q, stale_d;

    logic [INSTR_W-1:0]  ibuf_q [BUF_DEPTH];
    logic [ADDR_W-1:0]   abuf_q [BUF_DEPTH];
    logic [PTR_W-1:0]    wr_q, rd_q;
    logic [CNT_W-1:0]    count_q;

    logic [ADDR_W-1:0]   tag_q [BUF_DEPTH];
    logic [PTR_W-1:0]    tag_wr_q, tag_rd_q;

    logic                credit_ok;
    logic                req_fire;
    logic                push;
    logic                pop;

    assign credit_ok   = (SUM_W'(outst_q) + SUM_W'(count_q)) < SUM_W'(BUF_DEPTH);
    assign req_fire    = imem_req_valid && imem_req_ready;
    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready;
    assign push        = (state_q == S_FETCH) && imem_rsp_valid && !PCSrc;

    assign imem_req_addr = pc_q;
    assign Instruction   = ibuf_q[rd_q];
    assign Address       = abuf_q[rd_q];

    // State, PC and request credit registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            outst_q <= '0;
            stale_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            stale_q <= stale_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        outst_d        = outst_q;
        stale_d        = stale_q;
        imem_req_valid = 1'b0;

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req_valid = credit_ok && !reset;
                if (req_fire) begin
                    pc_d = pc_q + ADDR_W'(4);
                end
                outst_d = outst_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
            end
            S_DRAIN: begin
                if (imem_rsp_valid && (stale_q != '0)) begin
                    stale_d = stale_q - CNT_W'(1);
                end
                if (stale_d == '0) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        // Redirect: everything in flight becomes stale; a response this cycle is already dropped
        if (PCSrc) begin
            pc_d = BranchAddress & ~ADDR_W'(3);
            if (state_q == S_FETCH) begin
                stale_d = outst_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
                outst_d = '0;
                state_d = (stale_d != '0) ? S_DRAIN : S_FETCH;
            end
        end
    end

    // Instruction FIFO plus the in-order tag (request PC) queue
    always_ff @(posedge clk) begin
        if (reset) begin
            ibuf_q   <= '{default: '0};
            abuf_q   <= '{default: '0};
            tag_q    <= '{default: '0};
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
        end else if (PCSrc) begin
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
        end else begin
            if (req_fire) begin
                tag_q[tag_wr_q] <= pc_q;
                tag_wr_q        <= tag_wr_q + PTR_W'(1);
            end
            if (push) begin
                ibuf_q[wr_q] <= imem_rsp_data;
                abuf_q[wr_q] <= tag_q[tag_rd_q];
                wr_q         <= wr_q + PTR_W'(1);
                tag_rd_q     <= tag_rd_q + PTR_W'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] flush_cnt_q;

    // Counters wrap silently at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pop) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (PCSrc) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_fetch_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: fixed-latency memory model, expected-address scoreboard,
// directed phases for reset, back-pressure, redirect/drain and perf counters.
module tb_instruction_fetch;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam logic [31:0] XMASK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        PCSrc = 1'b0;
    logic [63:0] BranchAddress = '0;
    logic [31:0] Instruction;
    logic [63:0] Address;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;

    instruction_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .PCSrc          (PCSrc),
        .BranchAddress  (BranchAddress),
        .Instruction    (Instruction),
        .Address        (Address),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    int          n_acc = 0;
    int          n_pop = 0;
    logic [63:0] exp_pc = '0;
    mreq_t       mq[$];
    logic [63:0] exp_q[$];
    logic [63:0] got_addr[$];
    logic [31:0] got_instr[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] got_at(input int idx);
        return (got_addr.size() > idx) ? got_addr[idx] : '1;
    endfunction

    // Memory (reset along with the DUT) and request-side scoreboard
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            mq.delete();
            exp_q.delete();
            exp_pc = '0;
            n_acc  = 0;
            n_pop  = 0;
            imem_rsp_valid <= 1'b0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, exp_pc);
                n_acc++;
                mq.push_back('{addr: imem_req_addr, due: cyc + mem_lat - 1});
                if (!PCSrc) exp_q.push_back(exp_pc);
                exp_pc = exp_pc + 64'd4;
            end
            if (PCSrc) begin
                exp_q.delete();
                exp_pc = BranchAddress & ~64'h3;
            end
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mq[0].addr[31:0] ^ XMASK;
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    // Decode-side monitor: every pop must match the oldest live expected address
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            logic [63:0] a;
            n_pop++;
            got_addr.push_back(Address);
            got_instr.push_back(Instruction);
            chk("pop_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                a = exp_q.pop_front();
                chk("pop_addr", Address, a);
                chk("pop_instr", {32'd0, Instruction}, {32'd0, a[31:0] ^ XMASK});
            end
        end
    end

    initial begin
        int          first;
        int          found;
        int          hit;
        logic [31:0] bad_word;

        // Phase 1: reset state, latency, in-order stream
        mem_lat = 1;
        step(2);
        chk("rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_instr", {32'd0, Instruction}, 64'd0);
        chk("rst_addr", Address, 64'd0);
        chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rst_perf_fetch", {32'd0, perf_fetch_cnt}, 64'd0);
        chk("rst_perf_flush", {32'd0, perf_flush_cnt}, 64'd0);
        got_addr.delete();
        got_instr.delete();
        reset = 1'b0;
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            if (instr_valid) begin
                first = i;
                break;
            end
        end
        chk("first_valid_latency", 64'(first), 64'd3);
        step(10);
        for (int i = 0; i < 4; i++) chk("p1_addr_seq", got_at(i), 64'(4 * i));

        // Phase 2: decode stalled, credit limit, then release
        instr_ready = 1'b0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        got_addr.delete();
        got_instr.delete();
        step(12);
        chk("stall_accepts", 64'(n_acc), 64'd2);
        chk("stall_req_valid", {63'd0, imem_req_valid}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", {63'd0, instr_valid}, 64'd1);
            chk("stall_addr", Address, 64'd0);
            chk("stall_instr", {32'd0, Instruction}, {32'd0, XMASK});
            step(1);
        end
        instr_ready = 1'b1;
        step(12);
        for (int i = 0; i < 4; i++) chk("p2_addr_seq", got_at(i), 64'(4 * i));

        // Phase 3: redirect with two requests outstanding at 3-cycle latency
        mem_lat = 3;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(3);
        chk("p3_outstanding", 64'(n_acc), 64'd2);
        PCSrc = 1'b1;
        BranchAddress = 64'h100;
        step(1);
        PCSrc = 1'b0;
        got_addr.delete();
        got_instr.delete();
        chk("drain_req_valid0", {63'd0, imem_req_valid}, 64'd0);
        chk("drain_instr_valid", {63'd0, instr_valid}, 64'd0);
        step(1);
        chk("drain_req_valid1", {63'd0, imem_req_valid}, 64'd0);
        step(1);
        chk("post_drain_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("post_drain_req_addr", imem_req_addr, 64'h100);
        step(20);
        chk("p3_first_addr", got_at(0), 64'h100);
        chk("p3_second_addr", got_at(1), 64'h104);

        // Phase 4: misaligned target, redirect coinciding with a response
        mem_lat = 1;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(6);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (imem_rsp_valid) begin
                found = 1;
                break;
            end
        end
        chk("rsp_seen", 64'(found), 64'd1);
        bad_word = imem_rsp_data;
        PCSrc = 1'b1;
        BranchAddress = 64'h203;
        step(1);
        PCSrc = 1'b0;
        chk("flush_valid", {63'd0, instr_valid}, 64'd0);
        got_addr.delete();
        got_instr.delete();
        step(12);
        chk("p4_first_addr", got_at(0), 64'h200);
        chk("p4_second_addr", got_at(1), 64'h204);
        hit = 0;
        foreach (got_instr[i]) if (got_instr[i] == bad_word) hit = 1;
        chk("redirect_rsp_dropped", 64'(hit), 64'd0);

        // Phase 5: reset in the middle of a drain
        mem_lat = 3;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(3);
        PCSrc = 1'b1;
        BranchAddress = 64'h100;
        step(1);
        PCSrc = 1'b0;
        reset = 1'b1;
        step(1);
        chk("mid_rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("mid_rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("mid_rst_addr", Address, 64'd0);
        step(1);
        reset = 1'b0;
        got_addr.delete();
        got_instr.delete();
        step(20);
        chk("p5_first_addr", got_at(0), 64'd0);
        chk("p5_second_addr", got_at(1), 64'd4);

        // Phase 6: five single pops and two redirects for the perf counters
        mem_lat = 1;
        instr_ready = 1'b0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(6);
        for (int i = 0; i < 5; i++) begin
            chk("perf_pre_valid", {63'd0, instr_valid}, 64'd1);
            instr_ready = 1'b1;
            step(1);
            instr_ready = 1'b0;
            step(3);
        end
        for (int i = 0; i < 2; i++) begin
            PCSrc = 1'b1;
            BranchAddress = 64'h300;
            step(1);
            PCSrc = 1'b0;
            step(4);
        end
        chk("perf_fetch_cnt", {32'd0, perf_fetch_cnt}, PERF ? 64'd5 : 64'd0);
        chk("perf_flush_cnt", {32'd0, perf_flush_cnt}, PERF ? 64'd2 : 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
